// File: rtl/floppy_voice_alloc.sv
// floppy_voice_alloc: allocates note-on/off events to floppy drive channels, stealing the oldest voice when full
module floppy_voice_alloc #(
  parameter int NUM_DRIVES = 4,
  parameter int SETPOINT_W = 22
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ev_valid,
  output logic                             ev_ready,
  input  logic                             ev_on,
  input  logic [6:0]                       ev_note,
  input  logic [SETPOINT_W-1:0]            ev_setpoint,
  input  logic                             all_off,
  output logic [NUM_DRIVES-1:0]            drv_enable,
  output logic [NUM_DRIVES*SETPOINT_W-1:0] drv_setpoint,
  output logic                             steal,
  output logic                             drop
);
  localparam int IW = $clog2(NUM_DRIVES);
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  state_t state;
  logic [IW-1:0] idx, match_idx, free_idx, old_idx, tgt;
  logic match_ok, free_ok, old_ok;
  logic [3:0] old_age;
  logic lat_on;
  logic [6:0] lat_note;
  logic [SETPOINT_W-1:0] lat_sp;
  logic [6:0] note [NUM_DRIVES];
  logic [SETPOINT_W-1:0] sp [NUM_DRIVES];
  logic [3:0] age [NUM_DRIVES];
  assign ev_ready = state == IDLE && !all_off;
  assign tgt = match_ok ? match_idx : free_ok ? free_idx : old_idx;
  for (genvar g = 0; g < NUM_DRIVES; g++) begin : g_sp
    assign drv_setpoint[g*SETPOINT_W +: SETPOINT_W] = sp[g];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      drv_enable <= '0;
      steal <= 1'b0;
      drop <= 1'b0;
      idx <= '0;
      match_idx <= '0;
      free_idx <= '0;
      old_idx <= '0;
      match_ok <= 1'b0;
      free_ok <= 1'b0;
      old_ok <= 1'b0;
      old_age <= '0;
      lat_on <= 1'b0;
      lat_note <= '0;
      lat_sp <= '0;
      for (int i = 0; i < NUM_DRIVES; i++) begin
        note[i] <= '0;
        sp[i] <= '0;
        age[i] <= '0;
      end
    end else begin
      steal <= 1'b0;
      drop <= 1'b0;
      if (all_off) begin
        state <= IDLE;
        drv_enable <= '0;
        for (int i = 0; i < NUM_DRIVES; i++) age[i] <= '0;
      end else begin
        case (state)
          IDLE: if (ev_valid) begin
            lat_on <= ev_on;
            lat_note <= ev_note;
            lat_sp <= ev_setpoint;
            idx <= '0;
            match_ok <= 1'b0;
            free_ok <= 1'b0;
            old_ok <= 1'b0;
            old_age <= '0;
            state <= SCAN;
          end
          SCAN: begin
            if (drv_enable[idx] && note[idx] == lat_note && !match_ok) begin
              match_ok <= 1'b1;
              match_idx <= idx;
            end
            if (!drv_enable[idx] && !free_ok) begin
              free_ok <= 1'b1;
              free_idx <= idx;
            end
            // strict > keeps the lowest index on equal ages
            if (drv_enable[idx] && (!old_ok || age[idx] > old_age)) begin
              old_ok <= 1'b1;
              old_idx <= idx;
              old_age <= age[idx];
            end
            idx <= idx + 1'b1;
            if (idx == IW'(NUM_DRIVES - 1)) state <= COMMIT;
          end
          default: begin
            state <= IDLE;
            if (lat_on && lat_sp == '0) drop <= 1'b1;
            else if (lat_on) begin
              steal <= !match_ok && !free_ok;
              for (int i = 0; i < NUM_DRIVES; i++) begin
                if (IW'(i) == tgt) begin
                  drv_enable[i] <= 1'b1;
                  note[i] <= lat_note;
                  sp[i] <= lat_sp;
                  age[i] <= '0;
                end else if (drv_enable[i] && age[i] != 4'hf) age[i] <= age[i] + 4'd1;
              end
            end else if (match_ok) begin
              drv_enable[match_idx] <= 1'b0;
              age[match_idx] <= '0;
            end else drop <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_floppy_voice_alloc.sv
// tb_floppy_voice_alloc: directed table, corner sequences and random events against a voice model
module tb_floppy_voice_alloc;
  localparam int N = 4;
  localparam int SW = 22;
  logic clk = 0, rst_n = 0, ev_valid = 0, ev_on = 0, all_off = 0;
  logic ev_ready, steal, drop;
  logic [6:0] ev_note = 0;
  logic [SW-1:0] ev_setpoint = 0;
  logic [N-1:0] drv_enable;
  logic [N*SW-1:0] drv_setpoint;
  int checks = 0, errors = 0;
  bit m_act [N];
  int m_note [N];
  int m_age [N];
  logic [SW-1:0] m_sp [N];
  typedef struct {
    logic on;
    logic [6:0] note;
    logic [SW-1:0] sp;
    logic [N-1:0] en;
    logic stl;
    logic drp;
    int drv;
    logic [SW-1:0] dsp;
  } vec_t;
  vec_t tbl [10];

  floppy_voice_alloc #(.NUM_DRIVES(N), .SETPOINT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on),
    .ev_note(ev_note), .ev_setpoint(ev_setpoint), .all_off(all_off), .drv_enable(drv_enable),
    .drv_setpoint(drv_setpoint), .steal(steal), .drop(drop));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int j = 0; j < N; j++) begin
      m_act[j] = 0;
      m_age[j] = 0;
    end
  endtask

  task automatic model_ev(input logic on, input int n, input logic [SW-1:0] s,
                          output logic es, output logic ed);
    int m = -1, f = -1, o = -1, t;
    es = 0;
    ed = 0;
    for (int j = 0; j < N; j++) begin
      if (m_act[j] && m_note[j] == n && m < 0) m = j;
      if (!m_act[j] && f < 0) f = j;
      if (m_act[j] && (o < 0 || m_age[j] > m_age[o])) o = j;
    end
    if (on && s == 0) ed = 1;
    else if (on) begin
      t = m >= 0 ? m : f >= 0 ? f : o;
      es = m < 0 && f < 0;
      for (int j = 0; j < N; j++)
        if (j != t && m_act[j]) m_age[j] = m_age[j] < 15 ? m_age[j] + 1 : 15;
      m_act[t] = 1;
      m_note[t] = n;
      m_sp[t] = s;
      m_age[t] = 0;
    end else if (m >= 0) begin
      m_act[m] = 0;
      m_age[m] = 0;
    end else ed = 1;
  endtask

  task automatic compare(input string tag, input logic es, input logic ed);
    logic [N-1:0] een;
    logic [N*SW-1:0] ebus;
    for (int j = 0; j < N; j++) begin
      een[j] = m_act[j];
      ebus[j*SW +: SW] = m_sp[j];
    end
    check({tag, ".enable"}, 128'(drv_enable), 128'(een));
    check({tag, ".setpoints"}, 128'(drv_setpoint), 128'(ebus));
    check({tag, ".steal"}, 128'(steal), 128'(es));
    check({tag, ".drop"}, 128'(drop), 128'(ed));
  endtask

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (!ev_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("ready_wait", 128'(ev_ready), 128'(1));
  endtask

  // issue one event, return after outputs of its COMMIT are visible
  task automatic ev(input string tag, input logic on, input int n, input logic [SW-1:0] s);
    logic es, ed;
    wait_ready();
    ev_valid = 1;
    ev_on = on;
    ev_note = 7'(n);
    ev_setpoint = s;
    @(posedge clk);
    #1 ev_valid = 0;
    ev_on = 0;
    ev_note = 0;
    ev_setpoint = 0;
    check({tag, ".busy"}, 128'(ev_ready), 128'(0));
    repeat (N + 1) @(posedge clk);
    #1;
    model_ev(on, n, s, es, ed);
    compare(tag, es, ed);
  endtask

  task automatic pulse_all_off();
    @(negedge clk);
    all_off = 1;
    #1 check("alloff.ready_low", 128'(ev_ready), 128'(0));
    @(negedge clk);
    all_off = 0;
    model_clear();
    #1 check("alloff.enable", 128'(drv_enable), 128'(0));
    check("alloff.ready", 128'(ev_ready), 128'(1));
  endtask

  initial begin
    tbl[0] = '{1'b1, 7'd60, 22'd1000, 4'b0001, 1'b0, 1'b0, 0, 22'd1000};
    tbl[1] = '{1'b1, 7'd62, 22'd2000, 4'b0011, 1'b0, 1'b0, 1, 22'd2000};
    tbl[2] = '{1'b1, 7'd60, 22'd1500, 4'b0011, 1'b0, 1'b0, 0, 22'd1500};
    tbl[3] = '{1'b0, 7'd62, 22'd0,    4'b0001, 1'b0, 1'b0, 1, 22'd2000};
    tbl[4] = '{1'b0, 7'd62, 22'd0,    4'b0001, 1'b0, 1'b1, 1, 22'd2000};
    tbl[5] = '{1'b1, 7'd64, 22'd0,    4'b0001, 1'b0, 1'b1, 0, 22'd1500};
    tbl[6] = '{1'b1, 7'd62, 22'd2000, 4'b0011, 1'b0, 1'b0, 1, 22'd2000};
    tbl[7] = '{1'b1, 7'd64, 22'd100,  4'b0111, 1'b0, 1'b0, 2, 22'd100};
    tbl[8] = '{1'b1, 7'd65, 22'd200,  4'b1111, 1'b0, 1'b0, 3, 22'd200};
    tbl[9] = '{1'b1, 7'd67, 22'd3000, 4'b1111, 1'b1, 1'b0, 0, 22'd3000};
    for (int j = 0; j < N; j++) begin
      m_act[j] = 0;
      m_note[j] = 0;
      m_age[j] = 0;
      m_sp[j] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    check("reset.enable", 128'(drv_enable), 128'(0));
    check("reset.setpoints", 128'(drv_setpoint), 128'(0));
    check("reset.ready", 128'(ev_ready), 128'(1));
    check("reset.steal", 128'(steal), 128'(0));
    check("reset.drop", 128'(drop), 128'(0));
    for (int i = 0; i < 10; i++) begin
      ev($sformatf("tbl%0d", i), tbl[i].on, int'(tbl[i].note), tbl[i].sp);
      check($sformatf("tbl%0d.en", i), 128'(drv_enable), 128'(tbl[i].en));
      check($sformatf("tbl%0d.steal", i), 128'(steal), 128'(tbl[i].stl));
      check($sformatf("tbl%0d.drop", i), 128'(drop), 128'(tbl[i].drp));
      check($sformatf("tbl%0d.sp", i), 128'(drv_setpoint[tbl[i].drv*SW +: SW]), 128'(tbl[i].dsp));
      @(posedge clk);
      #1 check($sformatf("tbl%0d.pulse_end", i), 128'({steal, drop}), 128'(0));
    end
    pulse_all_off();
    ev("pre60", 1, 60, 1000);
    ev("pre62", 1, 62, 2000);
    check("pre.enable", 128'(drv_enable), 128'(4'b0011));
    // all_off while note 70 is mid-scan: the event must vanish
    wait_ready();
    ev_valid = 1;
    ev_on = 1;
    ev_note = 70;
    ev_setpoint = 777;
    @(posedge clk);
    #1 ev_valid = 0;
    @(negedge clk);
    @(negedge clk);
    all_off = 1;
    @(posedge clk);
    #1 check("abort.enable", 128'(drv_enable), 128'(0));
    check("abort.ready_low", 128'(ev_ready), 128'(0));
    @(negedge clk);
    all_off = 0;
    model_clear();
    #1 check("abort.ready", 128'(ev_ready), 128'(1));
    for (int k = 0; k < N + 2; k++) begin
      @(posedge clk);
      #1 check("abort.quiet", 128'({drv_enable, steal, drop}), 128'(0));
    end
    compare("abort.final", 0, 0);
    // all_off beats a simultaneous handshake
    @(negedge clk);
    all_off = 1;
    ev_valid = 1;
    ev_on = 1;
    ev_note = 71;
    ev_setpoint = 500;
    #1 check("prio.ready", 128'(ev_ready), 128'(0));
    @(negedge clk);
    all_off = 0;
    ev_valid = 0;
    repeat (N + 3) @(posedge clk);
    #1 compare("prio", 0, 0);
    for (int r = 0; r < 300; r++) begin
      logic on;
      logic [SW-1:0] s;
      on = $urandom_range(0, 9) < 6;
      s = $urandom_range(0, 7) == 0 ? '0 : SW'($urandom_range(1, 4000000));
      if ($urandom_range(0, 24) == 0) pulse_all_off();
      ev($sformatf("rnd%0d", r), on, 60 + $urandom_range(0, 5), s);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/floppy_voice_alloc.md
# floppy_voice_alloc

Polyphonic voice allocator that sits between the MIDI note decoder and an array of `floppy` drive channels. It accepts note-on and note-off events over a valid/ready handshake and assigns each note to a drive. For every drive it owns the `enable` and `setpoint` inputs of the corresponding `floppy` instance. When all drives are busy it steals the oldest voice, so at most NUM_DRIVES notes sound at once.

## Interface
- NUM_DRIVES, 4: number of floppy channels managed; range 2..8.
- SETPOINT_W, 22: width of the period setpoint passed to each drive.
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- ev_valid  in  1  event present.
- ev_ready  out  1  block can accept an event; high only in IDLE.
- ev_on  in  1  1 = note-on, 0 = note-off.
- ev_note  in  7  MIDI note number, 0..127.
- ev_setpoint  in  SETPOINT_W  half-period count from the upstream note-to-period table; used on note-on only.
- all_off  in  1  level; silences every drive.
- drv_enable  out  NUM_DRIVES  per-drive enable; bit i drives `enable` of drive i.
- drv_setpoint  out  NUM_DRIVES*SETPOINT_W  flat bus; drive i occupies bits [i*SETPOINT_W +: SETPOINT_W].
- steal  out  1  one-cycle pulse when a note-on evicts an active voice.
- drop  out  1  one-cycle pulse when an accepted event changes nothing (see Operation).

## Operation
- Per-drive state:
  - `active` (equals drv_enable[i])
  - `note[6:0]`
  - `setpoint`
  - `age[3:0]`
- FSM states:
  - IDLE: ev_ready=1. On ev_valid&ev_ready, latch ev_on/ev_note/ev_setpoint, clear scan results, go to SCAN with index=0.
  - SCAN: examines drive `index` each cycle. It records:
    - first match, meaning active && note==ev_note;
    - first free, meaning !active;
    - oldest active, meaning maximum age, with strict > so the lowest index wins ties.
  - SCAN continues with index+1. After index NUM_DRIVES-1 it goes to COMMIT.
  - COMMIT: applies the decision below, then returns to IDLE.
- Note-on decision:
  - The target is the matching drive if one exists (retrigger). Otherwise it is the lowest free drive. Otherwise it is the oldest active drive, with steal=1.
  - The target gets active=1, note=ev_note, setpoint=ev_setpoint and age=0.
  - Every other active drive gets age+1, saturating at 15. Inactive drives' ages are untouched.
- Note-on with ev_setpoint==0 is ignored and pulses drop. No drive or age changes.
- Note-off decision:
  - With a match, that drive gets active=0 and age=0; its setpoint is retained.
  - With no match, pulse drop; nothing changes.
  - Ages of other drives are unchanged on note-off.
- all_off, sampled every cycle in any state:
  - Next edge: all active=0, all ages=0, FSM to IDLE. Setpoints are retained.
  - An event already accepted and in SCAN/COMMIT is discarded, with no drop pulse.
  - all_off has priority over an IDLE handshake in the same cycle: ev_ready is forced low while all_off=1, so no event is accepted.
- Reset (rst_n=0 at an edge):
  - FSM to IDLE.
  - drv_enable=0, every setpoint=0, every note=0, every age=0.
  - steal=0, drop=0.
  - ev_ready=1 from the first cycle after reset while all_off=0.

## Timing
- Handshake: accept on the rising edge where ev_valid&ev_ready, at cycle T.
- Cycle-level sequence:
  - SCAN occupies cycles T+1..T+NUM_DRIVES.
  - COMMIT is cycle T+NUM_DRIVES+1.
  - Drive outputs, steal and drop are registered. They change on the edge ending COMMIT and are visible from cycle T+NUM_DRIVES+2.
- ev_ready returns high in cycle T+NUM_DRIVES+2. Throughput is one event per NUM_DRIVES+2 cycles; with the default 4, that is 6 cycles.
- steal and drop are high for exactly one cycle, in T+NUM_DRIVES+2.
- Input hold rules:
  - ev_* inputs need only be valid in the accept cycle; they are latched.
  - ev_valid may stay high; the next event is taken when ev_ready reasserts.
- drv_enable and drv_setpoint of one drive always change on the same edge. A drive never sees a new setpoint with a stale enable.

## Test plan
- Reset with NUM_DRIVES=4 → drv_enable=0000, all setpoints 0, ev_ready=1.
- Note-on 60/1000, then 62/2000 → drv_enable=0001, then 0011. Drive0 setpoint=1000, drive1 setpoint=2000. Each output changes 6 cycles after its accept; ev_ready is low for those cycles.
- Note-on 60/1000, 62, 64, 65, then 67/3000 → 67 steals drive0 (age 3, oldest): steal pulses once, drive0 setpoint=3000, drv_enable stays 1111.
- Note-on 60/1000 twice with setpoint 1500 on the second → retrigger: drv_enable=0001, drive0 setpoint=1500, no steal.
- Note-off 62 when 62 is not sounding → drop pulses once, outputs unchanged. Note-on with setpoint 0 → drop pulses, unchanged.
- all_off asserted 2 cycles after accepting note-on 70 with drives 0011 active → next cycle drv_enable=0000 and ev_ready=1 once all_off falls. Note 70 is never allocated; no steal/drop pulse.
